pipe_stage_chain: RTL and testbench
===================================

# pipe_stage_chain

Parametrised elastic pipeline register chain that sits between processor pipeline stages (fetch→decode, decode→execute, execute→writeback) in place of fixed inter-stage registers. It carries an arbitrary-width payload through `STAGES` register slots under a valid/ready handshake. It adds per-cycle stall back-pressure, a synchronous flush for branch/jump redirect, and an occupancy count for the hazard logic. With `out_ready` held high it behaves as a plain `STAGES`-deep pipeline at one transfer per cycle.

## Interface
- `DATA_W`, 32: payload width in bits (≥1).
- `STAGES`, 2: number of register slots (≥1).
- `CNT_W`, `$clog2(STAGES+1)`: occupancy counter width (derived, not overridden).

- `clk`  in  1: rising-edge clock; the only clock.
- `rst`  in  1: asynchronous, active-high reset.
- `in_valid`  in  1: upstream payload valid.
- `in_data`  in  `DATA_W`: upstream payload.
- `in_ready`  out  1: chain accepts `in_data` this cycle.
- `out_valid`  out  1: slot `STAGES-1` holds a valid payload.
- `out_data`  out  `DATA_W`: payload of slot `STAGES-1`.
- `out_ready`  in  1: downstream consumes `out_data` this cycle.
- `flush`  in  1: discard every in-flight payload (redirect).
- `occupancy`  out  `CNT_W`: number of valid slots, 0..`STAGES`.

## Operation
- State: per slot i (0 = input side, `STAGES-1` = output side), a valid bit `v[i]` and a payload register `d[i]`.
- Output handshake: transfer occurs when `out_valid && out_ready && !flush`.
- Advance rule: `adv[STAGES-1] = v[STAGES-1] ? (out_ready && !flush) : 1`. For i < `STAGES-1`, `adv[i] = !v[i+1] || adv[i+1]`. Ready propagates combinationally from output to input, so bubbles collapse and back-to-back throughput is full.
- Input handshake: `in_ready = adv[0] && !flush`. Accept when `in_valid && in_ready`.
- Slot update, non-flush cycle, when `adv[i]`:
  - Slot 0 loads `in_data`, with `v[0] = in_valid`.
  - Slot i>0 loads `d[i-1]`, with `v[i] = v[i-1]`.
  - When `!adv[i]`, slot i holds both `v` and `d`.
- Payload registers load only when the incoming valid is 1. They hold their old value otherwise, which saves power. Verification checks `out_data` only while `out_valid` = 1.
- Flush: on a clock edge with `flush` = 1, all `v[i]` clear to 0 and `d` are unchanged. During the flush cycle `in_ready` = 0 and `out_valid` = 0, so no transfer happens at either end. Flush takes priority over every other event.
- Occupancy: a registered count equal to the popcount of `v`.
  - Increments on accept without emit.
  - Decrements on emit without accept.
  - Unchanged when both or neither occur.
  - Forced to 0 by flush.
  - Never exceeds `STAGES` and never goes below 0. An assertion is required.
- Ordering: payloads leave in acceptance order. None is duplicated or dropped except by flush.

## Timing
- Reset (async assert, synchronous-release expected upstream): all `v` = 0, all `d` = 0, `occupancy` = 0. In reset, `out_valid` = 0, `out_data` = 0 and `in_ready` = 1 (unless `flush`).
- Latency: a payload accepted at edge N is presented on `out_valid`/`out_data` after edge N+`STAGES-1` when the chain ahead is empty. For `STAGES` = 1 it is presented immediately after the accepting edge.
- Throughput: one payload per cycle while `out_ready` = 1.
- Full: `occupancy` = `STAGES` with `out_ready` = 0 gives `in_ready` = 0. If `out_ready` = 1 in the same cycle, `in_ready` = 1: a simultaneous push and pop is allowed and occupancy stays unchanged.
- Empty: `out_valid` = 0. `out_ready` is ignored and no emit is counted.
- Combinational paths: `out_ready` → `in_ready` and `flush` → `in_ready`/`out_valid` only. No path runs from `in_valid` to `out_valid`.
- Reset asserted mid-transfer discards all contents immediately, without waiting for a clock edge.

## Test plan
- Reset: assert `rst` mid-stream with 2 payloads in flight → `out_valid` = 0, `occupancy` = 0, `in_ready` = 1, all without a clock edge.
- Streaming, `STAGES` = 3, `out_ready` = 1: push 0x11, 0x22, 0x33 on consecutive cycles → they emerge on 3 consecutive cycles starting 2 edges after the first accept, with `occupancy` peaking at 3.
- Back-pressure: `STAGES` = 2, hold `out_ready` = 0 and push 0xA, 0xB, 0xC → 0xA and 0xB are accepted and `in_ready` = 0 with 0xC held. Release `out_ready` → 0xA, 0xB, 0xC are delivered in order, none lost.
- Full simultaneous push/pop: `occupancy` = `STAGES`, `out_ready` = 1, `in_valid` = 1 → accept and emit in the same cycle, `occupancy` unchanged.
- Flush: 2 payloads in flight, `flush` = 1 for one cycle with `in_valid` = 1 and data 0x55 → no emit, 0x55 not accepted, `occupancy` = 0 next cycle. Then push 0x66 → 0x66 is the next payload out.
- Bubble collapse, `STAGES` = 4: push on alternate cycles with `out_ready` = 0, then raise `out_ready` → outputs are emitted back-to-back with no gaps, and `occupancy` decrements by 1 per cycle to 0.

Source files
------------

// File: rtl/pipe_stage_chain.sv
// rtl/pipe_stage_chain.sv - elastic valid/ready register chain with flush and occupancy
// Drop-in replacement for fixed inter-stage pipeline registers; bubbles collapse under stall.
module pipe_stage_chain #(
    parameter int DATA_W = 32,
    parameter int STAGES = 2,
    localparam int CNT_W = $clog2(STAGES + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    input  logic              flush,
    output logic [CNT_W-1:0]  occupancy
);

    localparam logic [CNT_W-1:0] MAX_OCC = CNT_W'(STAGES);

    logic [STAGES-1:0] v_q, v_d;
    logic [STAGES-1:0] adv;
    logic [DATA_W-1:0] d_q [STAGES];
    logic [DATA_W-1:0] d_d [STAGES];
    logic [CNT_W-1:0]  occ_q, occ_d;
    logic              accept, emit;

    // A slot may be overwritten when it is empty or its content moves on this cycle.
    always_comb begin
        logic ahead;
        adv   = '0;
        ahead = out_ready && !flush;
        for (int i = STAGES - 1; i >= 0; i--) begin
            ahead  = !v_q[i] || ahead;
            adv[i] = ahead;
        end
    end

    assign in_ready  = adv[0] && !flush;
    assign out_valid = v_q[STAGES-1] && !flush;
    assign out_data  = d_q[STAGES-1];
    assign occupancy = occ_q;
    assign accept    = in_valid && in_ready;
    assign emit      = out_valid && out_ready;

    always_comb begin
        v_d = v_q;
        d_d = d_q;
        if (flush) begin
            v_d = '0;
        end else begin
            if (adv[0]) begin
                v_d[0] = in_valid;
                if (in_valid) d_d[0] = in_data;
            end
            for (int i = 1; i < STAGES; i++) begin
                if (adv[i]) begin
                    v_d[i] = v_q[i-1];
                    if (v_q[i-1]) d_d[i] = d_q[i-1];
                end
            end
        end
    end

    always_comb begin
        occ_d = occ_q;
        if (flush)
            occ_d = '0;
        else if (accept && !emit)
            occ_d = occ_q + CNT_W'(1);
        else if (emit && !accept)
            occ_d = occ_q - CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q   <= '0;
            occ_q <= '0;
            for (int i = 0; i < STAGES; i++) d_q[i] <= '0;
        end else begin
            v_q   <= v_d;
            occ_q <= occ_d;
            for (int i = 0; i < STAGES; i++) d_q[i] <= d_d[i];
        end
    end

    always @(posedge clk) begin
        if (!rst) begin
            assert (occ_q <= MAX_OCC);
            assert (occ_q == CNT_W'($countones(v_q)));
        end
    end

endmodule

// File: tb/tb_pipe_stage_chain.sv
// tb/tb_pipe_stage_chain.sv - directed self-checking bench for pipe_stage_chain
module tb_pipe_stage_chain;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       iv2, ir2, ov2, or2, fl2;
    logic [7:0] id2, od2;
    logic [1:0] oc2;
    logic       iv3, ir3, ov3, or3, fl3;
    logic [7:0] id3, od3;
    logic [1:0] oc3;
    logic       iv4, ir4, ov4, or4, fl4;
    logic [7:0] id4, od4;
    logic [2:0] oc4;

    int n_chk  = 0;
    int n_fail = 0;

    pipe_stage_chain #(.DATA_W(8), .STAGES(2)) u2 (
        .clk(clk), .rst(rst), .in_valid(iv2), .in_data(id2), .in_ready(ir2),
        .out_valid(ov2), .out_data(od2), .out_ready(or2), .flush(fl2), .occupancy(oc2));
    pipe_stage_chain #(.DATA_W(8), .STAGES(3)) u3 (
        .clk(clk), .rst(rst), .in_valid(iv3), .in_data(id3), .in_ready(ir3),
        .out_valid(ov3), .out_data(od3), .out_ready(or3), .flush(fl3), .occupancy(oc3));
    pipe_stage_chain #(.DATA_W(8), .STAGES(4)) u4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_data(id4), .in_ready(ir4),
        .out_valid(ov4), .out_data(od4), .out_ready(or4), .flush(fl4), .occupancy(oc4));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #1;
        n_chk++; if (ov2 !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %0b want 0", ov2); end
        n_chk++; if (od2 !== 8'h00) begin n_fail++; $display("FAIL rst_out_data: got %0h want 0", od2); end
        n_chk++; if (ir2 !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %0b want 1", ir2); end
        n_chk++; if (oc2 !== 2'd0) begin n_fail++; $display("FAIL rst_occ: got %0d want 0", oc2); end
        tick();
        rst = 1'b0;
        or2 = 1'b0;
        iv2 = 1'b1; id2 = 8'h01; tick();
        id2 = 8'h02; tick();
        iv2 = 1'b0;
        n_chk++; if (oc2 !== 2'd2) begin n_fail++; $display("FAIL rst_pre_occ: got %0d want 2", oc2); end
        n_chk++; if (ov2 !== 1'b1) begin n_fail++; $display("FAIL rst_pre_valid: got %0b want 1", ov2); end
        #2 rst = 1'b1;
        #1;
        n_chk++; if (ov2 !== 1'b0) begin n_fail++; $display("FAIL rst_async_valid: got %0b want 0", ov2); end
        n_chk++; if (oc2 !== 2'd0) begin n_fail++; $display("FAIL rst_async_occ: got %0d want 0", oc2); end
        n_chk++; if (ir2 !== 1'b1) begin n_fail++; $display("FAIL rst_async_ready: got %0b want 1", ir2); end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_streaming;
        logic [7:0] din  [6] = '{8'h11, 8'h22, 8'h33, 8'h00, 8'h00, 8'h00};
        logic       dv   [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic       e_ov [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [7:0] e_od [6] = '{8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h00};
        logic [1:0] e_oc [6] = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0};
        or3 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            iv3 = dv[k]; id3 = din[k];
            tick();
            n_chk++; if (ov3 !== e_ov[k]) begin n_fail++; $display("FAIL stream_valid[%0d]: got %0b want %0b", k, ov3, e_ov[k]); end
            if (e_ov[k]) begin
                n_chk++; if (od3 !== e_od[k]) begin n_fail++; $display("FAIL stream_data[%0d]: got %0h want %0h", k, od3, e_od[k]); end
            end
            n_chk++; if (oc3 !== e_oc[k]) begin n_fail++; $display("FAIL stream_occ[%0d]: got %0d want %0d", k, oc3, e_oc[k]); end
        end
    endtask

    task automatic test_back_pressure;
        or2 = 1'b0;
        iv2 = 1'b1; id2 = 8'h0A;
        n_chk++; if (ir2 !== 1'b1) begin n_fail++; $display("FAIL bp_ready_a: got %0b want 1", ir2); end
        tick();
        id2 = 8'h0B;
        n_chk++; if (ir2 !== 1'b1) begin n_fail++; $display("FAIL bp_ready_b: got %0b want 1", ir2); end
        tick();
        id2 = 8'h0C;
        n_chk++; if (ir2 !== 1'b0) begin n_fail++; $display("FAIL bp_ready_c: got %0b want 0", ir2); end
        tick();
        n_chk++; if (ir2 !== 1'b0) begin n_fail++; $display("FAIL bp_held_ready: got %0b want 0", ir2); end
        n_chk++; if (oc2 !== 2'd2) begin n_fail++; $display("FAIL bp_held_occ: got %0d want 2", oc2); end
        n_chk++; if (od2 !== 8'h0A) begin n_fail++; $display("FAIL bp_held_data: got %0h want 0a", od2); end
        or2 = 1'b1;
        #1;
        n_chk++; if (ir2 !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %0b want 1", ir2); end
        tick();
        iv2 = 1'b0;
        n_chk++; if (od2 !== 8'h0B || ov2 !== 1'b1) begin n_fail++; $display("FAIL bp_out_b: got %0h/%0b want 0b/1", od2, ov2); end
        n_chk++; if (oc2 !== 2'd2) begin n_fail++; $display("FAIL bp_pushpop_occ: got %0d want 2", oc2); end
        tick();
        n_chk++; if (od2 !== 8'h0C || ov2 !== 1'b1) begin n_fail++; $display("FAIL bp_out_c: got %0h/%0b want 0c/1", od2, ov2); end
        tick();
        n_chk++; if (ov2 !== 1'b0 || oc2 !== 2'd0) begin n_fail++; $display("FAIL bp_drain: got %0b/%0d want 0/0", ov2, oc2); end
    endtask

    task automatic test_full_push_pop;
        or3 = 1'b0;
        iv3 = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            id3 = 8'(k); tick();
        end
        id3 = 8'h04;
        n_chk++; if (oc3 !== 2'd3 || ir3 !== 1'b0) begin n_fail++; $display("FAIL full_stall: got occ %0d ready %0b want 3/0", oc3, ir3); end
        or3 = 1'b1;
        #1;
        n_chk++; if (ir3 !== 1'b1) begin n_fail++; $display("FAIL full_pushpop_ready: got %0b want 1", ir3); end
        tick();
        iv3 = 1'b0;
        n_chk++; if (oc3 !== 2'd3 || od3 !== 8'h02) begin n_fail++; $display("FAIL full_pushpop: got occ %0d data %0h want 3/02", oc3, od3); end
        tick();
        n_chk++; if (oc3 !== 2'd2 || od3 !== 8'h03) begin n_fail++; $display("FAIL full_drain1: got occ %0d data %0h want 2/03", oc3, od3); end
        tick();
        n_chk++; if (oc3 !== 2'd1 || od3 !== 8'h04) begin n_fail++; $display("FAIL full_drain2: got occ %0d data %0h want 1/04", oc3, od3); end
        tick();
        n_chk++; if (oc3 !== 2'd0 || ov3 !== 1'b0) begin n_fail++; $display("FAIL full_empty: got occ %0d valid %0b want 0/0", oc3, ov3); end
    endtask

    task automatic test_flush;
        or2 = 1'b0;
        iv2 = 1'b1; id2 = 8'h41; tick();
        id2 = 8'h42; tick();
        fl2 = 1'b1; or2 = 1'b1; id2 = 8'h55;
        #1;
        n_chk++; if (ov2 !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid: got %0b want 0", ov2); end
        n_chk++; if (ir2 !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready: got %0b want 0", ir2); end
        tick();
        fl2 = 1'b0; iv2 = 1'b0;
        n_chk++; if (oc2 !== 2'd0 || ov2 !== 1'b0) begin n_fail++; $display("FAIL flush_after: got occ %0d valid %0b want 0/0", oc2, ov2); end
        iv2 = 1'b1; id2 = 8'h66; tick();
        iv2 = 1'b0; tick();
        n_chk++; if (ov2 !== 1'b1 || od2 !== 8'h66) begin n_fail++; $display("FAIL flush_next: got %0b/%0h want 1/66", ov2, od2); end
        tick();
        n_chk++; if (oc2 !== 2'd0 || ov2 !== 1'b0) begin n_fail++; $display("FAIL flush_drain: got occ %0d valid %0b want 0/0", oc2, ov2); end
    endtask

    task automatic test_bubble_collapse;
        logic [2:0] e_oc [8] = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd4, 3'd4};
        logic [7:0] e_od [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
        or4 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            iv4 = (k % 2 == 0);
            id4 = 8'(k / 2 + 1);
            tick();
            n_chk++; if (oc4 !== e_oc[k]) begin n_fail++; $display("FAIL bubble_fill_occ[%0d]: got %0d want %0d", k, oc4, e_oc[k]); end
        end
        iv4 = 1'b0;
        n_chk++; if (ir4 !== 1'b0) begin n_fail++; $display("FAIL bubble_full_ready: got %0b want 0", ir4); end
        or4 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_chk++; if (ov4 !== 1'b1 || od4 !== e_od[k]) begin n_fail++; $display("FAIL bubble_out[%0d]: got %0b/%0h want 1/%0h", k, ov4, od4, e_od[k]); end
            tick();
            n_chk++; if (oc4 !== 3'(3 - k)) begin n_fail++; $display("FAIL bubble_drain_occ[%0d]: got %0d want %0d", k, oc4, 3 - k); end
        end
        n_chk++; if (ov4 !== 1'b0) begin n_fail++; $display("FAIL bubble_empty: got %0b want 0", ov4); end
    endtask

    initial begin
        rst = 1'b1;
        {iv2, or2, fl2, iv3, or3, fl3, iv4, or4, fl4} = '0;
        id2 = '0; id3 = '0; id4 = '0;
        test_reset();
        test_streaming();
        test_back_pressure();
        test_full_push_pop();
        test_flush();
        test_bubble_collapse();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
